// File: rtl/braille_cell_driver.sv
// braille_cell_driver: buffers 6-bit braille cells from the translator in a
// FIFO and plays them out on the actuator pins. Each cell is held for
// HOLD_CYCLES cycles, then all pins drop for GAP_CYCLES cycles. pin_strobe
// pulses on the first cycle a new cell is driven.
//
// Optional build macro: BRAILLE_SPACE_COLLAPSE_EN -- when defined, runs of
// consecutive space cells (000000) are collapsed to a single space in the FIFO.
module braille_cell_driver #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [5:0]               in_cell,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [5:0]               pins,
  output logic                     pin_strobe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // Counter only ever holds 0 .. MAX_C-1.
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  logic [5:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             wr_en;
  logic             pop;
  logic             fifo_empty;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [5:0]       pins_d;
  logic             strobe_d;
  logic             advance;

  // A full FIFO stalls the translator even if a pop happens this cycle.
  assign in_ready   = (fifo_count < FULL) && !clear;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign busy       = (state != IDLE) || !fifo_empty;

`ifdef BRAILLE_SPACE_COLLAPSE_EN
  logic last_space;

  // A space is still handshaken, but dropped if the previous accepted cell was a space.
  assign wr_en = push && !((in_cell == 6'b000000) && last_space);

  // Track whether the most recently accepted cell was a space.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n)     last_space <= 1'b0;
    else if (clear) last_space <= 1'b0;
    else if (push)  last_space <= (in_cell == 6'b000000);
  end
`else
  assign wr_en = push;
`endif

  // Cell storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy and pointers decide what is valid.
    if (wr_en) mem[wptr] <= in_cell;
  end

  // FIFO pointers and occupancy; clear wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (wr_en && !pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (pop && !wr_en) fifo_count <= fifo_count - CNT_ONE;
    end
  end

  // Next-state and registered-output logic for the playback FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    pins_d   = pins;
    strobe_d = 1'b0;
    pop      = 1'b0;
    advance  = 1'b0;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      pins_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          pins_d  = '0;
          advance = 1'b1;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              pins_d  = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt + TMR_ONE;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_d   = '0;
            advance = 1'b1;
          end else begin
            cnt_d = cnt + TMR_ONE;
          end
        end
        default: state_d = IDLE;
      endcase

      // End of a cell period (or idle): start the next cell if one is buffered.
      if (advance) begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          pins_d   = mem[rptr];
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD;
        end else begin
          pins_d  = '0;
          state_d = IDLE;
        end
      end
    end
  end

  // FSM state, cycle counter and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pins       <= '0;
      pin_strobe <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pins       <= pins_d;
      pin_strobe <= strobe_d;
    end
  end

endmodule

// File: tb/tb_braille_cell_driver.sv
// Self-checking bench for braille_cell_driver (default parameters).
// Expected cells go into a scoreboard queue when stimulus is issued; a monitor
// pops and compares on every pin_strobe.
module tb_braille_cell_driver;

  localparam int DEPTH  = 8;
  localparam int HOLD   = 4;
  localparam int GAP    = 1;
  localparam int PERIOD = HOLD + GAP;

`ifdef BRAILLE_SPACE_COLLAPSE_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_cell = '0;
  logic       in_ready;
  logic       clear = 1'b0;
  logic [5:0] pins;
  logic       pin_strobe;
  logic       busy;
  logic [3:0] fifo_count;

  braille_cell_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_cell    (in_cell),
    .in_ready   (in_ready),
    .clear      (clear),
    .pins       (pins),
    .pin_strobe (pin_strobe),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  int         strobe_cnt = 0;
  int         cyc_n = 0;
  int         last_strobe = -1;
  bit         spacing_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: every strobe must present the next expected cell.
  always @(negedge clk) begin
    if (pin_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got pins=%b expected no strobe", pins);
      end else begin
        check("cell_order", {26'b0, pins}, {26'b0, exp_q.pop_front()});
      end
      if (spacing_en) begin
        if (last_strobe >= 0) check("strobe_spacing", cyc_n - last_strobe, PERIOD);
        last_strobe = cyc_n;
      end
    end
  end

  // Offer one cell and return right after the edge that accepts it.
  task automatic send(input logic [5:0] c, input bit expect_shown);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_cell  = c;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 1);
    end else begin
      if (expect_shown) exp_q.push_back(c);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         m_count;
    bit         m_disp;
    int         m_phase;
    logic [5:0] nc;
    int         cyc;
    bit         exp_ready;
    bit         mpush;
    bit         mpop;
    bit         saw_full;
    int         s0;

    // Reset state
    #3;
    check("rst_pins", {26'b0, pins}, 0);
    check("rst_strobe", 32'(pin_strobe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", {28'b0, fifo_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 1);

    // Single cell: accepted at E0, shown E1..E4, gap after E5, idle after E6
    @(negedge clk);
    in_valid = 1'b1;
    in_cell  = 6'b101101;
    exp_q.push_back(6'b101101);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("single_e0_pins", {26'b0, pins}, 0);
    check("single_e0_count", {28'b0, fifo_count}, 1);
    check("single_e0_busy", 32'(busy), 1);
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      check("single_hold_pins", {26'b0, pins}, 32'b101101);
      check("single_hold_strobe", 32'(pin_strobe), (k == 1) ? 1 : 0);
    end
    @(negedge clk);
    check("single_gap_pins", {26'b0, pins}, 0);
    check("single_gap_busy", 32'(busy), 1);
    @(negedge clk);
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_pins", {26'b0, pins}, 0);

    // Back-pressure: in_valid held 20 cycles, checked against a cycle model
    spacing_en  = 1'b1;
    last_strobe = -1;
    m_count  = 0;
    m_disp   = 1'b0;
    m_phase  = 0;
    nc       = 6'd1;
    cyc      = 0;
    saw_full = 1'b0;
    do begin
      @(negedge clk);
      in_valid  = (cyc < 20);
      in_cell   = nc;
      exp_ready = (m_count < DEPTH);
      if (fifo_count == 4'(DEPTH)) saw_full = 1'b1;
      check("bp_in_ready", 32'(in_ready), 32'(exp_ready));
      check("bp_count", {28'b0, fifo_count}, m_count);
      @(posedge clk);
      mpush = in_valid && exp_ready;
      mpop  = 1'b0;
      if (!m_disp) begin
        if (m_count > 0) begin
          mpop    = 1'b1;
          m_disp  = 1'b1;
          m_phase = 0;
        end
      end else if (m_phase == PERIOD - 1) begin
        if (m_count > 0) begin
          mpop    = 1'b1;
          m_phase = 0;
        end else begin
          m_disp = 1'b0;
        end
      end else begin
        m_phase++;
      end
      if (mpush) begin
        exp_q.push_back(nc);
        nc++;
      end
      m_count = m_count + int'(mpush) - int'(mpop);
      cyc++;
    end while ((cyc < 20 || m_disp || m_count > 0) && cyc < 400);
    #1 in_valid = 1'b0;
    check("bp_drain_bound", 32'(cyc < 400), 1);
    check("bp_saw_full", 32'(saw_full), 1);
    @(negedge clk);
    check("bp_idle", 32'(busy), 0);
    spacing_en = 1'b0;

    // Space collapse
    s0 = strobe_cnt;
    send(6'b100000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b000000, !COLL);
    send(6'b000000, !COLL);
    send(6'b110000, 1'b1);
    wait_idle(100);
    check("collapse_strobes", strobe_cnt - s0, COLL ? 3 : 5);

    // Async reset mid-HOLD discards shown and buffered cells
    send(6'b010101, 1'b1);
    send(6'b001100, 1'b0);
    send(6'b111111, 1'b0);
    @(negedge clk);
    check("pre_rst_count", {28'b0, fifo_count}, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pins", {26'b0, pins}, 0);
    check("arst_strobe", 32'(pin_strobe), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_count", {28'b0, fifo_count}, 0);
    s0 = strobe_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_in_ready", 32'(in_ready), 1);
    repeat (30) @(negedge clk);
    check("arst_no_strobes", strobe_cnt - s0, 0);
    check("arst_busy_after", 32'(busy), 0);

    // Clear with 3 cells queued and a cell offered in the same cycle
    send(6'b000111, 1'b1);
    send(6'b011000, 1'b0);
    send(6'b100100, 1'b0);
    send(6'b110011, 1'b0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_cell  = 6'b101010;
    #1;
    check("clr_queued", {28'b0, fifo_count}, 3);
    check("clr_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    s0 = strobe_cnt;
    @(negedge clk);
    check("clr_count", {28'b0, fifo_count}, 0);
    check("clr_pins", {26'b0, pins}, 0);
    check("clr_strobe", 32'(pin_strobe), 0);
    clear    = 1'b0;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("clr_not_accepted", {28'b0, fifo_count}, 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_no_strobes", strobe_cnt - s0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
